// File: rtl/br_tag_alloc.sv
// rtl/br_tag_alloc.sv - branch-tag allocator and speculation tracker
//
// Hands out one-hot branch tags to dispatch and tracks which older branches
// each in-flight branch depends on. Execute reports resolution results. A
// correct resolution frees its tag. A misprediction flushes the tag and every
// younger tag, and requests a fetch redirect.
//
// Ports:
//   i_clk, i_rst     clock; synchronous active-high reset
//   i_alloc          dispatch wants a tag this cycle
//   o_gnt            allocation accepted (combinational)
//   o_tag            one-hot lowest free tag, zero when full (combinational)
//   o_mask           current busy mask, stamped onto dispatched uops
//   o_full           every tag is busy
//   i_res_valid      execute resolution valid
//   i_res_brmask     one-hot tag of the resolving branch
//   i_res_kill       resolution is a misprediction
//   i_res_PC         corrected target PC
//   o_redirect       registered one-cycle fetch restart pulse
//   o_redirect_PC    registered redirect target; holds when o_redirect=0
//   o_kill_mask      registered one-cycle mask of flushed tags
//   o_free_mask      registered one-cycle mask of correctly resolved tags

module br_tag_alloc #(
    parameter int WIDTH_BRM = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_alloc,
    output logic                 o_gnt,
    output logic [WIDTH_BRM-1:0] o_tag,
    output logic [WIDTH_BRM-1:0] o_mask,
    output logic                 o_full,
    input  logic                 i_res_valid,
    input  logic [WIDTH_BRM-1:0] i_res_brmask,
    input  logic                 i_res_kill,
    input  logic [31:0]          i_res_PC,
    output logic                 o_redirect,
    output logic [31:0]          o_redirect_PC,
    output logic [WIDTH_BRM-1:0] o_kill_mask,
    output logic [WIDTH_BRM-1:0] o_free_mask
);

    logic [WIDTH_BRM-1:0] busy;
    logic [WIDTH_BRM-1:0] dep      [WIDTH_BRM];
    logic [WIDTH_BRM-1:0] dep_nxt  [WIDTH_BRM];
    logic [WIDTH_BRM-1:0] busy_nxt;

    logic                 res_onehot;
    logic                 res_ok;
    logic                 kill;
    logic                 free_ok;
    logic [WIDTH_BRM-1:0] free_tag;
    logic                 free_found;
    logic [WIDTH_BRM-1:0] kill_set;
    logic [WIDTH_BRM-1:0] clear_set;
    logic [WIDTH_BRM-1:0] res_sel;

    // Lowest-index free tag; stays zero when every tag is busy.
    always_comb begin
        free_tag   = '0;
        free_found = 1'b0;
        for (int i = 0; i < WIDTH_BRM; i++) begin
            if (!busy[i] && !free_found) begin
                free_tag[i] = 1'b1;
                free_found  = 1'b1;
            end
        end
    end

    assign res_onehot = ($countones(i_res_brmask) == 1);
    assign res_ok     = i_res_valid && res_onehot && (|(i_res_brmask & busy));
    assign kill       = res_ok && i_res_kill;
    assign free_ok    = res_ok && !i_res_kill;
    assign res_sel    = res_ok ? i_res_brmask : '0;

    assign o_full = &busy;
    assign o_tag  = free_tag;
    assign o_mask = busy;
    // A kill squashes everything younger, so a same-cycle dispatch must retry.
    assign o_gnt  = i_alloc && !o_full && !kill;

    // Flush set: the killed tag plus every live tag that recorded it as older.
    always_comb begin
        kill_set = i_res_brmask;
        for (int j = 0; j < WIDTH_BRM; j++) begin
            if (busy[j] && (|(dep[j] & i_res_brmask))) begin
                kill_set[j] = 1'b1;
            end
        end
    end

    always_comb begin
        clear_set = '0;
        if (kill) begin
            clear_set = kill_set;
        end else if (free_ok) begin
            clear_set = i_res_brmask;
        end
    end

    // The new tag's dependency list excludes a branch resolving this cycle,
    // otherwise a later reuse of that tag would look like an older branch.
    always_comb begin
        busy_nxt = busy & ~clear_set;
        if (o_gnt) begin
            busy_nxt = busy_nxt | free_tag;
        end
        for (int j = 0; j < WIDTH_BRM; j++) begin
            dep_nxt[j] = dep[j] & ~clear_set;
            if (o_gnt && free_tag[j]) begin
                dep_nxt[j] = busy & ~res_sel;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy          <= '0;
            for (int j = 0; j < WIDTH_BRM; j++) begin
                dep[j] <= '0;
            end
            o_redirect    <= 1'b0;
            o_redirect_PC <= 32'h0;
            o_kill_mask   <= '0;
            o_free_mask   <= '0;
        end else begin
            busy <= busy_nxt;
            for (int j = 0; j < WIDTH_BRM; j++) begin
                dep[j] <= dep_nxt[j];
            end
            o_redirect  <= kill;
            o_kill_mask <= kill ? kill_set : '0;
            o_free_mask <= free_ok ? i_res_brmask : '0;
            if (kill) begin
                o_redirect_PC <= i_res_PC;
            end
        end
    end

endmodule

// File: tb/tb_br_tag_alloc.sv
// tb/tb_br_tag_alloc.sv - randomized check of br_tag_alloc against an age-ordered list model

module tb_br_tag_alloc;

    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc;
    logic          gnt;
    logic [W-1:0]  tag;
    logic [W-1:0]  mask;
    logic          full;
    logic          res_valid;
    logic [W-1:0]  res_brmask;
    logic          res_kill;
    logic [31:0]   res_pc;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [W-1:0]  kill_mask;
    logic [W-1:0]  free_mask;

    br_tag_alloc #(.WIDTH_BRM(W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_alloc       (alloc),
        .o_gnt         (gnt),
        .o_tag         (tag),
        .o_mask        (mask),
        .o_full        (full),
        .i_res_valid   (res_valid),
        .i_res_brmask  (res_brmask),
        .i_res_kill    (res_kill),
        .i_res_PC      (res_pc),
        .o_redirect    (redirect),
        .o_redirect_PC (redirect_pc),
        .o_kill_mask   (kill_mask),
        .o_free_mask   (free_mask)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: in-flight branches as tag indices in allocation order.
    // A kill of entry p removes p and everything after it.
    int          q[$];
    logic        e_red;
    logic [31:0] e_pc;
    logic [W-1:0] e_km;
    logic [W-1:0] e_fm;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] m_mask();
        logic [W-1:0] m = '0;
        foreach (q[i]) m[q[i]] = 1'b1;
        return m;
    endfunction

    function automatic int m_find(input int t);
        foreach (q[i]) if (q[i] == t) return i;
        return -1;
    endfunction

    task automatic cycle(input logic r, input logic a, input logic rv,
                         input logic [W-1:0] bm, input logic kl, input logic [31:0] pc);
        logic [W-1:0] m;
        logic [W-1:0] e_tag;
        logic         e_full, ok, e_kill, e_gnt;
        int           ti, ri, p;
        rst = r; alloc = a; res_valid = rv; res_brmask = bm; res_kill = kl; res_pc = pc;
        #1;
        m      = m_mask();
        e_full = (q.size() == W);
        e_tag  = '0;
        ti     = -1;
        for (int i = W - 1; i >= 0; i--) if (!m[i]) ti = i;
        if (ti >= 0) e_tag[ti] = 1'b1;
        ok     = rv && ($countones(bm) == 1) && ((m & bm) != 0);
        e_kill = ok && kl;
        e_gnt  = a && !e_full && !e_kill;
        check("tag",  {28'h0, tag},  {28'h0, e_tag});
        check("mask", {28'h0, mask}, {28'h0, m});
        check("full", {31'h0, full}, {31'h0, e_full});
        check("gnt",  {31'h0, gnt},  {31'h0, e_gnt});
        @(posedge clk);
        if (r) begin
            q.delete();
            e_red = 1'b0; e_pc = 32'h0; e_km = '0; e_fm = '0;
        end else begin
            e_red = 1'b0; e_km = '0; e_fm = '0;
            if (ok) begin
                ri = 0;
                for (int i = 0; i < W; i++) if (bm[i]) ri = i;
                p = m_find(ri);
                if (kl) begin
                    for (int i = p; i < q.size(); i++) e_km[q[i]] = 1'b1;
                    while (q.size() > p) void'(q.pop_back());
                    e_red = 1'b1;
                    e_pc  = pc;
                end else begin
                    q.delete(p);
                    e_fm = bm;
                end
            end
            if (e_gnt) q.push_back(ti);
        end
        @(negedge clk);
        check("redirect",    {31'h0, redirect},  {31'h0, e_red});
        check("redirect_pc", redirect_pc,        e_pc);
        check("kill_mask",   {28'h0, kill_mask}, {28'h0, e_km});
        check("free_mask",   {28'h0, free_mask}, {28'h0, e_fm});
    endtask

    task automatic idle(input logic a);
        cycle(1'b0, a, 1'b0, '0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [W-1:0] bm;
        rst = 1'b1; alloc = 1'b0; res_valid = 1'b0; res_brmask = '0; res_kill = 1'b0; res_pc = '0;
        e_red = 1'b0; e_pc = '0; e_km = '0; e_fm = '0;
        @(posedge clk);
        @(negedge clk);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 32'h0);
        check("rst_tag",  {28'h0, tag},  32'h1);
        check("rst_full", {31'h0, full}, 32'h0);

        // Fill all four, then one more request while full.
        for (int i = 0; i < 5; i++) idle(1'b1);
        check("fill_full", {31'h0, full}, 32'h1);

        // Correct resolve of 0010, then reallocate it.
        cycle(1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 32'h0);
        check("free_0010", {28'h0, free_mask}, 32'h2);
        check("busy_1101", {28'h0, mask},      32'hd);
        idle(1'b1);

        // Fresh: 0001,0010,0100 then kill 0010.
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        cycle(1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 32'h0000_0100);
        check("kill_mask_0110", {28'h0, kill_mask}, 32'h6);
        check("kill_pc",        redirect_pc,         32'h100);
        check("kill_busy",      {28'h0, mask},       32'h1);
        idle(1'b0);

        // Kill 0001 with a same-cycle alloc request.
        cycle(1'b0, 1'b1, 1'b1, 4'b0001, 1'b1, 32'h0000_0200);
        check("kill_alloc_tag", {28'h0, tag}, 32'h1);

        // Invalid resolutions: not one-hot, and a non-busy tag.
        idle(1'b1);
        idle(1'b1);
        cycle(1'b0, 1'b0, 1'b1, 4'b0011, 1'b1, 32'h0000_0300);
        cycle(1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, 32'h0000_0400);

        // Reset overriding a kill with three busy.
        idle(1'b1);
        cycle(1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 32'h0000_0500);
        check("rst_kill_tag", {28'h0, tag}, 32'h1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if (q.size() > 0 && $urandom_range(0, 9) < 8)
                bm = W'(1 << q[$urandom_range(0, q.size() - 1)]);
            else
                bm = W'($urandom_range(0, (1 << W) - 1));
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 1) == 1, bm, $urandom_range(0, 9) < 3, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
